mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra cycles a memory strobe is held beyond the first (range 0..15).
REQ-002 Parameter FAIR_LIMIT, default 4: consecutive data grants after which a pending fetch is served first; 0 disables the guard (range 0..15).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  instruction-fetch request; held with if_addr until if_ready.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata  output  32  fetched word; valid while if_ready=1.
REQ-008 if_ready  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data request; held with d_* inputs until d_ready.
REQ-010 d_we  input  1  1=store, 0=load.
REQ-011 d_byte  input  1  byte-mode access.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_rdata  output  32  load data; valid while d_ready=1.
REQ-015 d_ready  output  1  one-cycle data completion pulse.
REQ-016 mem_read  output  1  read strobe to the memory/MMU port.
REQ-017 mem_write  output  1  write strobe to the memory/MMU port.
REQ-018 mem_addr  output  32  address to memory port.
REQ-019 mem_wdata  output  32  write data to memory port.
REQ-020 mem_bytemode  output  1  byte-mode flag to memory port.
REQ-021 mem_rdata  input  32  read data from memory port.
REQ-022 if_stall, d_stall  output  1 each  if_req&~if_ready, d_req&~d_ready (combinational).

Function
REQ-023 FSM states IDLE, ACCESS, DONE; all mem_* outputs, *_rdata and *_ready are registered.
REQ-024 IDLE: if d_req=1 and not (FAIR_LIMIT>0, if_req=1 and starve_cnt>=FAIR_LIMIT) grant data; else if if_req=1 grant fetch; else stay IDLE.
REQ-025 On grant at edge k: latch owner, address, write data, we and byte flag (fetch: we=0, byte=0); load wait counter with WAIT_CYCLES; go ACCESS.
REQ-026 ACCESS: mem_read=~we or mem_write=we asserted for exactly WAIT_CYCLES+1 cycles; mem_addr/mem_wdata/mem_bytemode constant throughout.
REQ-027 ACCESS exit at edge k+WAIT_CYCLES+1: strobes drop, mem_rdata captured into owner's rdata register (loads/fetches only), go DONE.
REQ-028 DONE: owner's ready=1 for exactly one cycle, other ready=0; next edge returns to IDLE; mem_addr holds last value.
REQ-029 Latency: request sampled at edge k gives ready high from edge k+WAIT_CYCLES+2 to k+WAIT_CYCLES+3; peak throughput one access per WAIT_CYCLES+3 cycles.
REQ-030 if_ready and d_ready never high in the same cycle; at most one strobe asserted at any time.
REQ-031 starve_cnt (4 bits, saturating at 15): +1 on a data grant while if_req=1; cleared on any fetch grant or when if_req=0 in IDLE.
REQ-032 Simultaneous if_req and d_req with starve_cnt<FAIR_LIMIT: data wins; fetch waits, if_stall=1.
REQ-033 Requester dropping req mid-access: access still completes and ready still pulses; no abort.
REQ-034 Stores: d_rdata unchanged; d_ready still pulses.
REQ-035 No address decode in this block; UART and RAM selection stay downstream.

Reset
REQ-036 rst_n=0 immediately forces IDLE, mem_read=0, mem_write=0, if_ready=0, d_ready=0, starve_cnt=0, mem_addr/mem_wdata/if_rdata/d_rdata=0, mem_bytemode=0, including mid-ACCESS.
REQ-037 First grant occurs no earlier than the first rising edge after rst_n rises.

Verification
REQ-038 WAIT_CYCLES=1, if_req, if_addr=0x80000000, mem_rdata=0x3C088000 -> mem_read 2 cycles, if_ready one cycle at k+3, if_rdata=0x3C088000.
REQ-039 Same-cycle if_req and d_req (store 0x000000AB, byte, addr 0x80400003) -> data first: mem_write 2 cycles, mem_bytemode=1; then fetch granted; d_ready precedes if_ready.
REQ-040 FAIR_LIMIT=4, d_req held continuously with if_req -> after 4 data grants, 5th grant goes to fetch, starve_cnt=0.
REQ-041 rst_n pulsed low during ACCESS -> mem_read/mem_write 0 same cycle, no ready pulse; after release, pending request re-granted from IDLE.
REQ-042 WAIT_CYCLES=0, back-to-back loads -> strobe 1 cycle each, ready every 3 cycles, strobes never overlap.
REQ-043 d_req dropped after grant -> d_ready still pulses once, FSM returns to IDLE, no second grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single memory strobe port.
// Data has priority; a starvation counter hands the port to a waiting fetch after FAIR_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned FAIR_LIMIT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_bytemode,
  input  logic [31:0] mem_rdata,
  output logic        if_stall,
  output logic        d_stall,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [3:0] FAIR_LIM  = 4'(FAIR_LIMIT);
  localparam logic       FAIR_ON   = (FAIR_LIMIT != 0);

  state_e      state_q, state_d;
  logic        owner_d_q, owner_d_d;   // 1 = data port owns the current access
  logic        we_q, we_d;
  logic [3:0]  wait_q, wait_d;
  logic [3:0]  starve_q, starve_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_byte_q, mem_byte_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        fetch_first;

  // A starved fetch overrides data priority only while it is actually waiting.
  assign fetch_first = FAIR_ON && if_req && (starve_q >= FAIR_LIM);

  always_comb begin
    state_d     = state_q;
    owner_d_d   = owner_d_q;
    we_d        = we_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_byte_d  = mem_byte_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!if_req) starve_d = 4'd0;
        if (d_req && !fetch_first) begin
          owner_d_d   = 1'b1;
          we_d        = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_byte_d  = d_byte;
          mem_read_d  = ~d_we;
          mem_write_d = d_we;
          wait_d      = WAIT_INIT;
          state_d     = ACCESS;
          if (if_req && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
        end else if (if_req) begin
          owner_d_d   = 1'b0;
          we_d        = 1'b0;
          mem_addr_d  = if_addr;
          mem_byte_d  = 1'b0;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          wait_d      = WAIT_INIT;
          starve_d    = 4'd0;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q == 4'd0) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!we_q) begin
            if (owner_d_q) d_rdata_d  = mem_rdata;
            else           if_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE: begin
        // Ready is registered, so it shows in the cycle after DONE.
        if (owner_d_q) d_ready_d  = 1'b1;
        else           if_ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      we_q        <= 1'b0;
      wait_q      <= 4'd0;
      starve_q    <= 4'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_byte_q  <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_d_q   <= owner_d_d;
      we_q        <= we_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_byte_q  <= mem_byte_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  assign if_rdata       = if_rdata_q;
  assign if_ready       = if_ready_q;
  assign d_rdata        = d_rdata_q;
  assign d_ready        = d_ready_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_bytemode   = mem_byte_q;
  assign if_stall       = if_req & ~if_ready_q;
  assign d_stall        = d_req & ~d_ready_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance with WAIT_CYCLES=1/FAIR_LIMIT=4,
// second instance with WAIT_CYCLES=0 for back-to-back throughput.
module tb_mem_arbiter;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, d_byte;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_read, mem_write, mem_bytemode, if_stall, d_stall;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  logic        b_d_req;
  logic [31:0] b_d_addr;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_ready, b_d_ready, b_mem_read, b_mem_write, b_mem_bytemode, b_if_stall, b_d_stall;
  logic [1:0]  b_dbg_state;
  logic [3:0]  b_dbg_starve_cnt;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];      // {is_data, rdata}
  logic [31:0] exp_d;         // model of d_rdata, kept for stores
  int          strobe_len = 0;
  logic [31:0] strobe_addr;

  always #5 clk = ~clk;

  // Memory model: deterministic word per address, garbage when not strobed.
  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h3C08_8000;
    return {a[15:0], ~a[15:0]} ^ 32'h00FF_0000;
  endfunction

  assign mem_rdata   = mem_read   ? rdata_fn(mem_addr)   : 32'hDEAD_BEEF;
  assign b_mem_rdata = b_mem_read ? rdata_fn(b_mem_addr) : 32'hDEAD_BEEF;

  mem_arbiter #(.WAIT_CYCLES(W), .FAIR_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bytemode(mem_bytemode), .mem_rdata(mem_rdata),
    .if_stall(if_stall), .d_stall(d_stall),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  mem_arbiter #(.WAIT_CYCLES(0), .FAIR_LIMIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .if_req(1'b0), .if_addr(32'd0), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .d_req(b_d_req), .d_we(1'b0), .d_byte(1'b0), .d_addr(b_d_addr), .d_wdata(32'd0),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_bytemode(b_mem_bytemode), .mem_rdata(b_mem_rdata),
    .if_stall(b_if_stall), .d_stall(b_d_stall),
    .dbg_state(b_dbg_state), .dbg_starve_cnt(b_dbg_starve_cnt)
  );

  function automatic void check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endfunction

  // Scoreboard and strobe monitor on the main instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_len = 0;
    end else begin
      if (if_ready || d_ready) begin
        check("ready_exclusive", {if_ready, d_ready} == 2'b11, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_ready", {if_ready, d_ready}, 2'b00);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("completion", d_ready ? {1'b1, d_rdata} : {1'b0, if_rdata}, e);
        end
      end
      if (mem_read || mem_write) begin
        if (mem_read && mem_write) check("strobe_overlap", 2'b11, 2'b00);
        if (strobe_len == 0) strobe_addr = mem_addr;
        else if (mem_addr !== strobe_addr) check("addr_stable", mem_addr, strobe_addr);
        strobe_len++;
      end else if (strobe_len != 0) begin
        check("strobe_len", strobe_len, W + 1);
        strobe_len = 0;
      end
    end
  end

  task automatic run_until_idle(input int n0, output int nd, output int ni);
    int n;
    n = n0; nd = -1; ni = -1;
    for (int i = 0; i < 60; i++) begin
      if (!d_req && !if_req) break;
      @(negedge clk); n++;
      if (d_ready) begin d_req = 1'b0; nd = n; end
      if (if_ready) begin if_req = 1'b0; ni = n; end
    end
    check("idle_timeout", {d_req, if_req}, 2'b00);
  endtask

  task automatic drive_data(input logic we, input logic bm, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_byte = bm; d_addr = a; d_wdata = wd;
    if (!we) exp_d = rdata_fn(a);
    exp_q.push_back({1'b1, exp_d});
  endtask

  task automatic drive_fetch(input logic [31:0] a);
    if_req = 1'b1; if_addr = a;
    exp_q.push_back({1'b0, rdata_fn(a)});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int nd, ni, dcnt, strobes, last, n, bi;
    bit got, bad;

    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; exp_d = '0;
    b_d_req = 1'b0; b_d_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_ready", {if_ready, d_ready}, 2'b00);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'd0);
    check("rst_bytemode", mem_bytemode, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_starve", dbg_starve_cnt, 4'd0);
    rst_n = 1'b1;

    // Single fetch.
    @(negedge clk);
    drive_fetch(32'h8000_0000);
    run_until_idle(0, nd, ni);
    check("fetch_latency", ni, W + 3);
    check("fetch_rdata", if_rdata, 32'h3C08_8000);

    // Simultaneous store and fetch: data wins.
    @(negedge clk);
    drive_data(1'b1, 1'b1, 32'h8040_0003, 32'h0000_00AB);
    drive_fetch(32'h8000_0010);
    @(negedge clk);
    check("c_mem_write", {mem_write, mem_read}, 2'b10);
    check("c_bytemode", mem_bytemode, 1'b1);
    check("c_addr", mem_addr, 32'h8040_0003);
    check("c_wdata", mem_wdata, 32'h0000_00AB);
    check("c_if_stall", if_stall, 1'b1);
    run_until_idle(1, nd, ni);
    check("c_d_latency", nd, W + 3);
    check("c_if_latency", ni, 2 * (W + 3));

    // Fairness: data held with fetch pending.
    @(negedge clk);
    for (int i = 0; i < 4; i++) drive_data(1'b0, 1'b0, 32'h0000_1000, 32'd0);
    drive_fetch(32'h8000_0020);
    dcnt = 0; got = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (d_ready) dcnt++;
      if (if_ready) begin
        got = 1'b1;
        check("f_starve_clear", dbg_starve_cnt, 4'd0);
        d_req = 1'b0; if_req = 1'b0;
        break;
      end
    end
    check("f_fetch_seen", got, 1'b1);
    check("f_data_grants", dcnt, 4);
    d_req = 1'b0; if_req = 1'b0;

    // Reset during a data access with a fetch waiting.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_byte = 1'b0; d_addr = 32'h0000_0500;
    if_req = 1'b1; if_addr = 32'h8000_0040;
    @(negedge clk);
    check("r_strobe", mem_read, 1'b1);
    check("r_starve", dbg_starve_cnt, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    check("r_strobes_low", {mem_read, mem_write}, 2'b00);
    check("r_addr_clr", mem_addr, 32'd0);
    check("r_starve_clr", dbg_starve_cnt, 4'd0);
    check("r_state", dbg_state, 2'd0);
    repeat (2) @(negedge clk);
    check("r_no_ready", {if_ready, d_ready}, 2'b00);
    rst_n = 1'b1;
    exp_d = '0;
    drive_data(1'b0, 1'b0, 32'h0000_0500, 32'd0);
    drive_fetch(32'h8000_0040);
    run_until_idle(0, nd, ni);
    check("r_d_latency", nd, W + 3);
    check("r_if_latency", ni, 2 * (W + 3));

    // Data request withdrawn after grant.
    @(negedge clk);
    drive_data(1'b0, 1'b0, 32'h0000_2000, 32'd0);
    @(negedge clk);
    check("w_strobe", mem_read, 1'b1);
    d_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_ready) begin got = 1'b1; break; end
    end
    check("w_ready_seen", got, 1'b1);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (mem_read || mem_write || d_ready) bad = 1'b1;
    end
    check("w_no_regrant", bad, 1'b0);
    check("w_idle", dbg_state, 2'd0);

    // Word store leaves d_rdata untouched.
    drive_data(1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678);
    @(negedge clk);
    check("s_strobe", {mem_write, mem_read}, 2'b10);
    check("s_wdata", mem_wdata, 32'h1234_5678);
    check("s_bytemode", mem_bytemode, 1'b0);
    run_until_idle(1, nd, ni);
    check("s_latency", nd, W + 3);

    // Zero-wait instance, back-to-back loads.
    @(negedge clk);
    b_d_req = 1'b1; b_d_addr = 32'h0000_3000;
    n = 0; last = 0; bi = 0; strobes = 0; bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bi == 4) break;
      @(negedge clk); n++;
      if (b_mem_read) strobes++;
      if ((b_mem_read && b_mem_write) || b_if_ready) bad = 1'b1;
      if (b_d_ready) begin
        check("b_rdata", b_d_rdata, rdata_fn(b_d_addr));
        check("b_gap", n - last, 3);
        last = n; bi++;
        b_d_addr = b_d_addr + 32'd4;
        if (bi == 4) b_d_req = 1'b0;
      end
    end
    b_d_req = 1'b0;
    check("b_count", bi, 4);
    check("b_strobes", strobes, 4);
    check("b_overlap", bad, 1'b0);
    repeat (3) @(negedge clk);
    check("b_idle", b_dbg_state, 2'd0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
